mul_err_monitor: RTL
====================

MUL_ERR_MONITOR -- requirements
Module: mul_err_monitor

Interface
REQ-001 SHALL provide parameter N_LOG2, default 16, giving the run length as 2^N_LOG2 samples (legal range 1..20).
REQ-002 SHALL provide parameter SUM_W, default 16+N_LOG2, giving the error-sum width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins a run.
REQ-006 in_valid  in  1  a sample is present on x, y, z.
REQ-007 in_ready  out  1  the block accepts a sample this cycle.
REQ-008 x  in  8  unsigned multiplier operand.
REQ-009 y  in  8  unsigned multiplier operand.
REQ-010 z  in  16  product from the approximate 8x8 multiplier under test.
REQ-011 busy  out  1  a run is in progress (RUN or DRAIN).
REQ-012 done  out  1  the run is complete and the results are valid.
REQ-013 sum_ed  out  SUM_W  sum of error distances |x*y - z| over the run.
REQ-014 max_ed  out  16  largest single error distance in the run.
REQ-015 err_cnt  out  N_LOG2+1  number of samples with z != x*y.

Function
REQ-016 SHALL implement an FSM with four states:
- IDLE -> RUN on start.
- RUN -> DRAIN when the 2^N_LOG2-th sample is accepted.
- DRAIN -> DONE when the pipeline is empty.
- DONE -> RUN on start.
REQ-017 SHALL drive in_ready=1 only in RUN; a sample is accepted when in_valid && in_ready.
REQ-018 SHALL clear sum_ed, max_ed, err_cnt and the sample counter on the IDLE->RUN and DONE->RUN transitions.
REQ-019 SHALL ignore start while in RUN or DRAIN.
REQ-020 SHALL process each sample in a 3-stage pipeline:
- S1 registers x, y, z and the valid flag.
- S2 computes the exact 16-bit product and registers ed = |exact - z|, using a 17-bit signed difference and taking the magnitude.
- S3 updates sum_ed += ed, max_ed = max(max_ed, ed), and err_cnt += (ed != 0).
REQ-021 SHALL update the accumulators exactly 3 cycles after the sample's acceptance edge.
REQ-022 SHALL advance pipeline stages every cycle (no stall); bubbles carry valid=0 and leave the accumulators unchanged.
REQ-023 SHALL enter DONE on the cycle after the last sample's S3 update, so done rises 4 cycles after the final acceptance edge.
REQ-024 SHALL hold done=1 and the result outputs stable throughout DONE.
REQ-025 SHALL saturate sum_ed at all-ones; with the default SUM_W this cannot occur.
REQ-026 SHALL give err_cnt enough width to hold a value of exactly 2^N_LOG2.
REQ-027 SHALL drive busy=1 exactly in RUN and DRAIN, and done=1 exactly in DONE.
REQ-028 SHALL handle start arriving in the same cycle as the DRAIN->DONE transition by completing that transition only; the start is ignored.

Reset
REQ-029 SHALL, when rst_n is low, immediately force the FSM to IDLE and clear all pipeline valid flags, counters and accumulators.
REQ-030 SHALL, while rst_n is low, drive in_ready=0, busy=0, done=0, sum_ed=0, max_ed=0, err_cnt=0.
REQ-031 SHALL abort any partial run on reset assertion mid-run, with no results retained.
REQ-032 SHALL require a fresh start after reset deassertion before accepting any sample.

Verification (N_LOG2=2 unless noted)
REQ-033 Exact run: start, then 4 samples with z=x*y ((3,5,15), (255,255,65025), (0,7,0), (16,16,256)) -> done, sum_ed=0, max_ed=0, err_cnt=0.
REQ-034 Error run: samples (255,255,z=61440), (10,10,z=96), (2,3,z=6), (1,1,z=3) -> sum_ed=3585+4+0+2=3591, max_ed=3585, err_cnt=3.
REQ-035 Handshake: in_valid toggled with gaps and start pulsed during RUN -> exactly 4 acceptances, start ignored, done rises 4 cycles after the 4th accept, and in_ready=0 from DRAIN onward.
REQ-036 Reset mid-run: rst_n pulsed low after 2 accepts -> all outputs 0 asynchronously, FSM in IDLE; the following start gives a clean 4-sample run with correct totals.
REQ-037 Restart: start issued in DONE -> accumulators clear to 0 on the next edge and a second run reports only its own samples.
REQ-038 Worst-case sum: N_LOG2=4 with 16 samples of (255,255,z=0) -> sum_ed=1040400, max_ed=65025, err_cnt=16, with no overflow.

Source files
------------

// File: rtl/mul_err_monitor_if.sv
// Sample/result bus of the approximate-multiplier error monitor.
// The master drives run control and samples; the slave returns the
// handshake, status flags and accumulated error statistics.
interface mul_err_monitor_if #(
    parameter int N_LOG2 = 16,
    parameter int SUM_W  = 16 + N_LOG2
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [15:0]       z;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  sum_ed;
    logic [15:0]       max_ed;
    logic [N_LOG2:0]   err_cnt;

    modport master (
        output start, in_valid, x, y, z,
        input  in_ready, busy, done, sum_ed, max_ed, err_cnt
    );

    modport slave (
        input  start, in_valid, x, y, z,
        output in_ready, busy, done, sum_ed, max_ed, err_cnt
    );
endinterface

// File: rtl/mul_err_monitor.sv
// mul_err_monitor: runs 2^N_LOG2 samples of an approximate 8x8 multiplier
// through an error-distance pipeline and reports the summed, largest and
// non-zero-count error distances against the exact product.
//
// Latency from the acceptance edge: the sample is captured into S1 on that
// edge, S2 registers the error distance one edge later, S3 holds it for one
// more edge, and the accumulators absorb it on the third edge. The FSM sees
// the pipeline empty one edge after that and enters DONE.
module mul_err_monitor #(
    parameter int N_LOG2 = 16,
    parameter int SUM_W  = 16 + N_LOG2
) (
    input logic              clk,
    input logic              rst_n,
    mul_err_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [N_LOG2-1:0] sample_cnt;

    logic              accept;
    logic              launch;
    logic              pipe_empty;

    // Pipeline control (reset) and datapath (not reset)
    logic              s1_valid;
    logic              s2_valid;
    logic              s3_valid;
    logic [7:0]        s1_x;
    logic [7:0]        s1_y;
    logic [15:0]       s1_z;
    logic [15:0]       s2_ed;
    logic [15:0]       s3_ed;

    // S2 combinational error-distance calculation
    logic [15:0]        product;
    logic signed [16:0] diff;
    logic [15:0]        ed_next;

    // Accumulators
    logic [SUM_W-1:0]  sum_ed;
    logic [15:0]       max_ed;
    logic [N_LOG2:0]   err_cnt;
    logic [SUM_W:0]    sum_wide;

    // in_ready is a registered copy of "state == RUN", so it is safe to use
    // directly in the acceptance term.
    assign accept     = bus.in_valid && in_ready;
    assign launch     = bus.start && ((state == IDLE) || (state == DONE));
    assign pipe_empty = !(s1_valid || s2_valid || s3_valid);

    // Run-control FSM with registered in_ready/busy/done outputs
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        sample_cnt <= '0;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here
                    if (accept) begin
                        sample_cnt <= sample_cnt + N_LOG2'(1);
                        if (sample_cnt == '1) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // A start coinciding with this transition is dropped
                    if (pipe_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline valid flags advance every cycle; bubbles carry valid=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Pipeline datapath registers
    // NOTE: the data registers are intentionally not reset; they are only
    // consumed when the matching valid flag (which is reset) is set.
    always_ff @(posedge clk) begin
        s1_x  <= bus.x;
        s1_y  <= bus.y;
        s1_z  <= bus.z;
        s2_ed <= ed_next;
        s3_ed <= s2_ed;
    end

    // Exact product and |exact - z| through a 17-bit signed difference
    // NOTE: every variable is assigned on every path, so no latch is inferred.
    always_comb begin
        product = {8'd0, s1_x} * {8'd0, s1_y};
        diff    = $signed({1'b0, product}) - $signed({1'b0, s1_z});
        ed_next = diff[16] ? 16'(-diff) : diff[15:0];
    end

    assign sum_wide = {1'b0, sum_ed} + {{(SUM_W + 1 - 16){1'b0}}, s3_ed};

    // Error statistics: cleared on a run launch, updated by each valid S3 sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (launch) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (s3_valid) begin
            // Saturate rather than wrap if the sum outgrows SUM_W
            sum_ed <= sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
            if (s3_ed > max_ed) begin
                max_ed <= s3_ed;
            end
            if (s3_ed != 16'd0) begin
                err_cnt <= err_cnt + (N_LOG2 + 1)'(1);
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.sum_ed   = sum_ed;
    assign bus.max_ed   = max_ed;
    assign bus.err_cnt  = err_cnt;

endmodule
